// File: rtl/matrix_host_port_pkg.sv
// matrix_host_port_pkg
//   Shared types and constants for the 2x2 matrix multiplier host port:
//   FSM state encoding, default element/result widths and the slot
//   packing helper used by both the operand loader and the result
//   serializer.
package matrix_host_port_pkg;

  localparam int ELEM_W  = 3;  // operand element width
  localparam int RES_W   = 6;  // result entry width
  localparam int N_ELEMS = 4;  // entries per 2x2 matrix

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // LSB position of slot k in a word packed from w-bit entries
  // (slot 0 in the least significant bits).
  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/matrix_host_port_result_serializer.sv
// result_serializer
//   Holds the captured multiplier result and streams it out one entry at
//   a time, entry 0 first.
//   Ports:
//     clock, reset     clock / async active-low reset
//     capture          load cap_data into the result register, rewind index
//     cap_data         packed result, entry k at [RES_W*k +: RES_W]
//     active           owner FSM is in its unload state (drives out_valid)
//     out_ready        consumer accepts the current entry
//     out_data         current entry, held while not accepted
//     last             handshake on the final entry this cycle
module result_serializer
  import matrix_host_port_pkg::*;
#(
  parameter int RES_W   = matrix_host_port_pkg::RES_W,
  parameter int N_ELEMS = matrix_host_port_pkg::N_ELEMS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     capture,
  input  logic [RES_W*N_ELEMS-1:0] cap_data,
  input  logic                     active,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_data,
  output logic                     last
);

  localparam int IW = $clog2(N_ELEMS);

  logic [RES_W*N_ELEMS-1:0] result;
  logic [IW-1:0]            res_idx;
  logic                     fire;

  assign fire     = active && out_ready;
  assign last     = fire && (res_idx == IW'(N_ELEMS - 1));
  // Index only moves on a handshake, so the entry is stable under stall.
  assign out_data = result[slot_lsb(int'(res_idx), RES_W) +: RES_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result  <= '0;
      res_idx <= '0;
    end else if (capture) begin
      result  <= cap_data;
      res_idx <= '0;
    end else if (fire) begin
      res_idx <= last ? '0 : res_idx + IW'(1);
    end
  end

endmodule

// File: rtl/matrix_host_port.sv
// matrix_host_port
//   Host front end for the 2x2 matrix multiplier. Collects eight serial
//   elements (A0..A3, B0..B3) into packed operand words, pulses mm_start,
//   waits LATENCY cycles, captures mm_result and returns its four entries
//   over an output valid/ready stream.
//   Ports:
//     clock, reset            clock / async active-low reset
//     in_valid/in_data/in_ready     element input stream
//     mm_matrix_A/B           packed operands, element k at [ELEM_W*k +: ELEM_W]
//     mm_start                one-cycle start pulse to the multiplier
//     mm_result               multiplier result, entry k at [RES_W*k +: RES_W]
//     out_valid/out_data/out_ready  result entry output stream
//     busy                    job in flight or partially loaded
//     job_count               completed jobs, mod 16
module matrix_host_port
  import matrix_host_port_pkg::*;
#(
  parameter int ELEM_W  = matrix_host_port_pkg::ELEM_W,
  parameter int RES_W   = matrix_host_port_pkg::RES_W,
  parameter int N_ELEMS = matrix_host_port_pkg::N_ELEMS,
  parameter int LATENCY = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [ELEM_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [ELEM_W*N_ELEMS-1:0] mm_matrix_A,
  output logic [ELEM_W*N_ELEMS-1:0] mm_matrix_B,
  output logic                      mm_start,
  input  logic [RES_W*N_ELEMS-1:0]  mm_result,
  output logic                      out_valid,
  output logic [RES_W-1:0]          out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [3:0]                job_count
);

  localparam int SW = $clog2(N_ELEMS);  // slot index width within one matrix
  localparam int CW = SW + 1;           // elem_cnt spans A and B
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state;
  logic [CW-1:0] elem_cnt;
  logic [WW-1:0] wait_cnt;
  logic          capture;
  logic          last;
  logic [SW-1:0] slot;
  logic          to_b;

  // Handshake flags decode from state only; no input feeds through.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign busy      = (state != LOAD) || (elem_cnt != '0);
  // Last WAIT cycle: mm_result is valid LATENCY cycles after mm_start.
  assign capture   = (state == WAIT) && (wait_cnt == WW'(LATENCY - 1));

  // Upper elem_cnt bit selects B; low bits are the slot within the matrix.
  assign slot = elem_cnt[SW-1:0];
  assign to_b = elem_cnt[SW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      elem_cnt    <= '0;
      wait_cnt    <= '0;
      mm_matrix_A <= '0;
      mm_matrix_B <= '0;
      mm_start    <= 1'b0;
      job_count   <= '0;
    end else begin
      mm_start <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (to_b) mm_matrix_B[slot_lsb(int'(slot), ELEM_W) +: ELEM_W] <= in_data;
            else      mm_matrix_A[slot_lsb(int'(slot), ELEM_W) +: ELEM_W] <= in_data;
            if (elem_cnt == CW'(2 * N_ELEMS - 1)) begin
              elem_cnt <= '0;
              mm_start <= 1'b1;  // registered: high for the single START cycle
              state    <= START;
            end else begin
              elem_cnt <= elem_cnt + CW'(1);
            end
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (capture) state    <= UNLOAD;
          else         wait_cnt <= wait_cnt + WW'(1);
        end
        UNLOAD: begin
          if (last) begin
            job_count <= job_count + 4'd1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  result_serializer #(
    .RES_W   (RES_W),
    .N_ELEMS (N_ELEMS)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .capture   (capture),
    .cap_data  (mm_result),
    .active    (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .last      (last)
  );

endmodule

// File: tb/tb_matrix_host_port.sv
// tb_matrix_host_port
//   Self-checking bench for matrix_host_port: table of jobs with expected
//   result entries, scoreboard queue for the output stream, plus reset and
//   wrap sequences.
module tb_matrix_host_port;

  localparam int LAT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_data = '0;
  logic        in_ready;
  logic [11:0] mm_matrix_A, mm_matrix_B;
  logic        mm_start;
  logic [23:0] mm_result;
  logic        out_valid;
  logic [5:0]  out_data;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [3:0]  job_count;

  always #5 clock = ~clock;

  matrix_host_port #(.LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mm_matrix_A (mm_matrix_A),
    .mm_matrix_B (mm_matrix_B),
    .mm_start    (mm_start),
    .mm_result   (mm_result),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .job_count   (job_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;   // cycle of the 8th accept
  int t_last  = 0;   // cycle of the 4th output handshake
  int exp_jobs = 0;
  bit ostall  = 0;
  logic [5:0] sbq[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioral multiplier: result only valid on the cycle LAT after mm_start.
  function automatic logic [23:0] mm_model(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] r;
    int ai[4];
    int bi[4];
    int c;
    for (int k = 0; k < 4; k++) begin
      ai[k] = int'(a[3*k +: 3]);
      bi[k] = int'(b[3*k +: 3]);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = ai[2*i] * bi[j] + ai[2*i+1] * bi[2+j];
        r[6*(2*i+j) +: 6] = c[5:0];
      end
    return r;
  endfunction

  logic [LAT-1:0] sh;
  always @(posedge clock or negedge reset)
    if (!reset) sh <= '0;
    else        sh <= {sh[LAT-2:0], mm_start};
  assign mm_result = sh[LAT-1] ? mm_model(mm_matrix_A, mm_matrix_B) : 24'hA5A5A5;

  typedef struct packed {
    logic [11:0] a;     // {a3,a2,a1,a0}
    logic [11:0] b;
    logic        gaps;
    logic        ostall;
    logic [23:0] exp;   // {e3,e2,e1,e0}
  } vec_t;
  vec_t vecs[6];

  // Output driver + monitor: one process so out_ready and the handshake
  // decision come from the same value.
  initial begin
    int ent = 0;
    int stalls = 0;
    bit was_stall = 0;
    logic [5:0] held = '0;
    logic prev_ov = 0;
    logic prev_st = 0;
    logic [5:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        out_ready = 1'b1; ent = 0; stalls = 0; was_stall = 0; prev_ov = 0; prev_st = 0;
        continue;
      end
      out_ready = !(ostall && out_valid && ent == 2 && stalls < 5);
      if (!out_ready) stalls++;
      if (mm_start) begin
        chk("start_cycle", cyc, t_acc + 1);
        chk("start_once", {31'd0, prev_st}, 0);
      end
      if (out_valid && !prev_ov) chk("latency", cyc - t_acc, LAT + 2);
      if (out_valid && was_stall) chk("hold", {26'd0, out_data}, {26'd0, held});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_entry: got %0d, want none", out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", {26'd0, out_data}, {26'd0, e});
        end
        ent = (ent == 3) ? 0 : ent + 1;
        if (ent == 0) begin t_last = cyc; stalls = 0; end
      end
      was_stall = out_valid && !out_ready;
      held      = out_data;
      prev_ov   = out_valid;
      prev_st   = mm_start;
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 1);
    chk({tag, "_mm_start"},  {31'd0, mm_start}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_data"},  {26'd0, out_data}, 0);
    chk({tag, "_A"},         {20'd0, mm_matrix_A}, 0);
    chk({tag, "_B"},         {20'd0, mm_matrix_B}, 0);
    chk({tag, "_busy"},      {31'd0, busy}, 0);
    chk({tag, "_job_count"}, {28'd0, job_count}, 0);
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1 reset_check(tag);
    sbq.delete();
    exp_jobs = 0;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic load_job(input logic [11:0] a, input logic [11:0] b,
                          input bit gaps, input bit junk);
    int w;
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(negedge clock); in_valid = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = (i < 4) ? a[3*i +: 3] : b[3*(i-4) +: 3];
      if (i > 0) chk("busy_midload", {31'd0, busy}, 1);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clock); w++; end
      if (w == 50) chk("in_ready_timeout", {31'd0, in_ready}, 1);
      if (i == 7) t_acc = cyc;
      @(posedge clock);
    end
    @(negedge clock);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 3'b110;
      repeat (LAT) begin
        @(negedge clock);
        chk("in_ready_busy", {31'd0, in_ready}, 0);
      end
    end
    in_valid = 1'b0;
    chk("mm_A", {20'd0, mm_matrix_A}, {20'd0, a});
    chk("mm_B", {20'd0, mm_matrix_B}, {20'd0, b});
  endtask

  task automatic run_job(input vec_t v, input bit junk);
    int w;
    ostall = v.ostall;
    for (int k = 0; k < 4; k++) sbq.push_back(v.exp[6*k +: 6]);
    load_job(v.a, v.b, v.gaps, junk);
    w = 0;
    while ((sbq.size() != 0 || !in_ready) && w < 100) begin @(negedge clock); w++; end
    if (w == 100) chk("job_timeout", sbq.size(), 0);
    else          chk("ready_after_last", cyc, t_last + 1);
    exp_jobs++;
    chk("job_count", {28'd0, job_count}, exp_jobs % 16);
    ostall = 0;
  endtask

  initial begin
    int w;
    vecs[0] = '{a: 12'o1001, b: 12'o5432, gaps: 0, ostall: 0, exp: 24'o05040302};
    vecs[1] = '{a: 12'o7777, b: 12'o7777, gaps: 0, ostall: 0, exp: 24'o42424242};
    vecs[2] = '{a: 12'o4321, b: 12'o0765, gaps: 1, ostall: 0, exp: 24'o22530623};
    vecs[3] = '{a: 12'o2002, b: 12'o7413, gaps: 0, ostall: 1, exp: 24'o16100206};
    vecs[4] = '{a: 12'o0000, b: 12'o5555, gaps: 0, ostall: 0, exp: 24'o00000000};
    vecs[5] = '{a: 12'o7653, b: 12'o4567, gaps: 1, ostall: 1, exp: 24'o00154656};

    #1 reset = 1'b0;
    #1 reset_check("por");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i], i == 1);

    // Reset during WAIT, then a clean job.
    for (int k = 0; k < 4; k++) sbq.push_back(vecs[0].exp[6*k +: 6]);
    load_job(vecs[0].a, vecs[0].b, 0, 0);
    repeat (3) @(negedge clock);
    pulse_reset("rst_wait");
    run_job(vecs[2], 0);

    // Reset during UNLOAD after two entries, then a clean job.
    for (int k = 0; k < 4; k++) sbq.push_back(vecs[5].exp[6*k +: 6]);
    load_job(vecs[5].a, vecs[5].b, 0, 0);
    w = 0;
    while (!out_valid && w < 40) begin @(negedge clock); w++; end
    if (w == 40) chk("unload_timeout", {31'd0, out_valid}, 1);
    repeat (2) @(negedge clock);
    pulse_reset("rst_unload");
    run_job(vecs[1], 0);

    // 17 jobs from reset: job_count wraps to 1.
    @(negedge clock);
    pulse_reset("rst_wrap");
    for (int j = 0; j < 17; j++) run_job(vecs[j % 6], j == 4);
    chk("wrap_job_count", {28'd0, job_count}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
